// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one single-port byte-masked RAM between the
// ceRV32 instruction-fetch port and the load/store data port.
module ram_port_arbiter #(
  parameter int ADDR_W     = 24,
  parameter bit DATA_FIRST = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,

  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_ack_o,
  output logic [31:0]       if_data_o,

  input  logic              d_req_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [31:0]       d_wdata_i,
  input  logic [3:0]        d_wmask_i,
  output logic              d_ack_o,
  output logic [31:0]       d_rdata_o,

  output logic [ADDR_W-1:0] ram_addr_o,
  output logic              ram_rstb_o,
  output logic [31:0]       ram_data_o,
  output logic [3:0]        ram_mask_o,
  input  logic [31:0]       ram_rdata_i,

  output logic              busy_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t state;
  logic   ptr_data;    // 1: data port wins the next tie
  logic   grant_data;  // grantee of the access in flight
  logic   grant_store; // in-flight data access is a store

  logic if_elig;
  logic d_elig;
  logic any_elig;
  logic pick_data;

  // A port whose ack is high this cycle still shows req; it must not be re-granted.
  assign if_elig   = if_req_i & ~if_ack_o;
  assign d_elig    = d_req_i  & ~d_ack_o;
  assign any_elig  = if_elig | d_elig;
  assign pick_data = d_elig & (~if_elig | ptr_data);

  // NOTE: every register here, outputs included, is updated with <= in one
  // clocked block so the reset, FSM and output timing stay in lockstep.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      ptr_data    <= DATA_FIRST;
      grant_data  <= 1'b0;
      grant_store <= 1'b0;
      if_ack_o    <= 1'b0;
      d_ack_o     <= 1'b0;
      if_data_o   <= '0;
      d_rdata_o   <= '0;
      ram_addr_o  <= '0;
      ram_rstb_o  <= 1'b0;
      ram_data_o  <= '0;
      ram_mask_o  <= '0;
      busy_o      <= 1'b0;
    end else begin
      if_ack_o <= 1'b0;
      d_ack_o  <= 1'b0;

      case (state)
        IDLE: begin
          if (any_elig) begin
            grant_data <= pick_data;
            ptr_data   <= ~pick_data;
            busy_o     <= 1'b1;
            state      <= ACCESS;
            if (pick_data) begin
              ram_addr_o  <= d_addr_i;
              ram_data_o  <= d_wdata_i;
              ram_mask_o  <= d_wmask_i;
              ram_rstb_o  <= (d_wmask_i == 4'b0000);
              grant_store <= (d_wmask_i != 4'b0000);
            end else begin
              // Fetches are read-only; write data keeps its last value.
              ram_addr_o  <= if_addr_i;
              ram_mask_o  <= 4'b0000;
              ram_rstb_o  <= 1'b1;
              grant_store <= 1'b0;
            end
          end
        end

        ACCESS: begin
          ram_rstb_o <= 1'b0;
          ram_mask_o <= 4'b0000;
          state      <= RESP;
        end

        RESP: begin
          if (grant_data) begin
            if (!grant_store) begin
              d_rdata_o <= ram_rdata_i;
            end
            d_ack_o <= 1'b1;
          end else begin
            if_data_o <= ram_rdata_i;
            if_ack_o  <= 1'b1;
          end
          busy_o <= 1'b0;
          state  <= IDLE;
        end

        default: begin
          ram_rstb_o <= 1'b0;
          ram_mask_o <= 4'b0000;
          busy_o     <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

  // Structural invariants of the access sequence.
  a_strobe_only_in_access: assert property (@(posedge clk_i) disable iff (rst_i)
    (ram_rstb_o || (ram_mask_o != 4'b0000)) |-> (state == ACCESS));

  a_fetch_never_writes: assert property (@(posedge clk_i) disable iff (rst_i)
    (ram_mask_o != 4'b0000) |-> grant_data);

  a_single_ack: assert property (@(posedge clk_i) disable iff (rst_i)
    !(if_ack_o && d_ack_o));

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed self-checking bench for ram_port_arbiter with a behavioural
// byte-masked RAM that has a one-cycle registered read.
module tb_ram_port_arbiter;

  localparam int ADDR_W = 24;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              if_req_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic              if_ack_o;
  logic [31:0]       if_data_o;
  logic              d_req_i;
  logic [ADDR_W-1:0] d_addr_i;
  logic [31:0]       d_wdata_i;
  logic [3:0]        d_wmask_i;
  logic              d_ack_o;
  logic [31:0]       d_rdata_o;
  logic [ADDR_W-1:0] ram_addr_o;
  logic              ram_rstb_o;
  logic [31:0]       ram_data_o;
  logic [3:0]        ram_mask_o;
  logic [31:0]       ram_rdata_i;
  logic              busy_o;

  int errors = 0;
  int checks = 0;

  always #5 clk_i = ~clk_i;

  ram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_FIRST(1'b1)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .if_req_i    (if_req_i),
    .if_addr_i   (if_addr_i),
    .if_ack_o    (if_ack_o),
    .if_data_o   (if_data_o),
    .d_req_i     (d_req_i),
    .d_addr_i    (d_addr_i),
    .d_wdata_i   (d_wdata_i),
    .d_wmask_i   (d_wmask_i),
    .d_ack_o     (d_ack_o),
    .d_rdata_o   (d_rdata_o),
    .ram_addr_o  (ram_addr_o),
    .ram_rstb_o  (ram_rstb_o),
    .ram_data_o  (ram_data_o),
    .ram_mask_o  (ram_mask_o),
    .ram_rdata_i (ram_rdata_i),
    .busy_o      (busy_o)
  );

  // RAM model: read samples the old word, writes apply byte lanes; the RAM
  // does not see the arbiter reset, so a store in ACCESS always commits.
  logic [31:0] mem [logic [21:0]];
  logic        pre_we = 1'b0;
  logic [21:0] pre_idx = '0;
  logic [31:0] pre_val = '0;

  always @(posedge clk_i) begin
    logic [21:0] k;
    logic [31:0] w;
    k = ram_addr_o[ADDR_W-1:2];
    w = mem.exists(k) ? mem[k] : 32'h0;
    if (ram_rstb_o) ram_rdata_i <= w;
    for (int b = 0; b < 4; b++) begin
      if (ram_mask_o[b]) w[8*b +: 8] = ram_data_o[8*b +: 8];
    end
    if (ram_mask_o != 4'b0000) mem[k] = w;
    if (pre_we) mem[pre_idx] = pre_val;
  end

  task automatic preload(input logic [23:0] addr, input logic [31:0] val);
    @(negedge clk_i);
    pre_we  = 1'b1;
    pre_idx = addr[23:2];
    pre_val = val;
    @(negedge clk_i);
    pre_we  = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i     = 1'b1;
    if_req_i  = 1'b0;
    if_addr_i = '0;
    d_req_i   = 1'b0;
    d_addr_i  = '0;
    d_wdata_i = '0;
    d_wmask_i = '0;
    ram_rdata_i = '0;
    preload(24'h000010, 32'h0010_0093);
    preload(24'h000014, 32'h1122_3344);
    preload(24'h000020, 32'h5555_5555);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if ({if_ack_o, d_ack_o, ram_rstb_o, ram_mask_o, busy_o} !== 8'h00) begin
      errors++;
      $display("FAIL reset_ctrl: got ack_if=%b ack_d=%b rstb=%b mask=%h busy=%b, want all 0",
               if_ack_o, d_ack_o, ram_rstb_o, ram_mask_o, busy_o);
    end
    checks++;
    if (ram_addr_o !== '0 || ram_data_o !== '0 || if_data_o !== '0 || d_rdata_o !== '0) begin
      errors++;
      $display("FAIL reset_data: got addr=%h wdata=%h if_data=%h d_rdata=%h, want 0",
               ram_addr_o, ram_data_o, if_data_o, d_rdata_o);
    end
  endtask

  task automatic test_fetch();
    @(negedge clk_i);
    if_addr_i = 24'h000010;
    if_req_i  = 1'b1;
    d_wmask_i = 4'hF;  // idle data port must not leak a mask onto the RAM
    for (int c = 0; c < 6; c++) begin
      if (c > 0) @(negedge clk_i);
      checks++;
      if (ram_rstb_o !== (c == 1) || ram_mask_o !== 4'h0) begin
        errors++;
        $display("FAIL fetch_strobe c%0d: got rstb=%b mask=%h, want rstb=%b mask=0",
                 c, ram_rstb_o, ram_mask_o, (c == 1));
      end
      checks++;
      if (if_ack_o !== (c == 3) || d_ack_o !== 1'b0) begin
        errors++;
        $display("FAIL fetch_ack c%0d: got if_ack=%b d_ack=%b, want if_ack=%b d_ack=0",
                 c, if_ack_o, d_ack_o, (c == 3));
      end
      if (c == 1) begin
        checks++;
        if (ram_addr_o !== 24'h000010) begin
          errors++;
          $display("FAIL fetch_addr: got %h want 000010", ram_addr_o);
        end
      end
      if (if_ack_o) if_req_i = 1'b0;
    end
    checks++;
    if (if_data_o !== 32'h0010_0093) begin
      errors++;
      $display("FAIL fetch_data: got %h want 00100093", if_data_o);
    end
    d_wmask_i = 4'h0;
  endtask

  task automatic test_store_load();
    @(negedge clk_i);
    d_addr_i  = 24'h000014;
    d_wdata_i = 32'hDEAD_BEEF;
    d_wmask_i = 4'b0011;
    d_req_i   = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) @(negedge clk_i);
      checks++;
      if (ram_mask_o !== ((c == 1) ? 4'b0011 : 4'b0000) || ram_rstb_o !== 1'b0) begin
        errors++;
        $display("FAIL store_mask c%0d: got mask=%h rstb=%b, want mask=%h rstb=0",
                 c, ram_mask_o, ram_rstb_o, (c == 1) ? 4'b0011 : 4'b0000);
      end
      checks++;
      if (d_ack_o !== (c == 3)) begin
        errors++;
        $display("FAIL store_ack c%0d: got %b want %b", c, d_ack_o, (c == 3));
      end
      if (d_ack_o) d_req_i = 1'b0;
    end
    checks++;
    if (d_rdata_o !== 32'h0) begin
      errors++;
      $display("FAIL store_rdata_held: got %h want 00000000", d_rdata_o);
    end
    @(negedge clk_i);
    d_wmask_i = 4'b0000;
    d_req_i   = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) @(negedge clk_i);
      checks++;
      if (ram_rstb_o !== (c == 1) || d_ack_o !== (c == 3)) begin
        errors++;
        $display("FAIL load_timing c%0d: got rstb=%b ack=%b, want rstb=%b ack=%b",
                 c, ram_rstb_o, d_ack_o, (c == 1), (c == 3));
      end
      if (d_ack_o) d_req_i = 1'b0;
    end
    checks++;
    if (d_rdata_o !== 32'h1122_BEEF) begin
      errors++;
      $display("FAIL load_data: got %h want 1122beef", d_rdata_o);
    end
  endtask

  task automatic test_tie();
    do_reset();
    @(negedge clk_i);
    if_addr_i = 24'h000010;
    d_addr_i  = 24'h000014;
    d_wmask_i = 4'b0000;
    if_req_i  = 1'b1;
    d_req_i   = 1'b1;
    for (int c = 0; c < 9; c++) begin
      if (c > 0) @(negedge clk_i);
      checks++;
      if (d_ack_o !== (c == 3) || if_ack_o !== (c == 6)) begin
        errors++;
        $display("FAIL tie_ack c%0d: got d_ack=%b if_ack=%b, want d_ack=%b if_ack=%b",
                 c, d_ack_o, if_ack_o, (c == 3), (c == 6));
      end
      checks++;
      if (busy_o !== (c == 1 || c == 2 || c == 4 || c == 5)) begin
        errors++;
        $display("FAIL tie_busy c%0d: got %b want %b", c, busy_o,
                 (c == 1 || c == 2 || c == 4 || c == 5));
      end
      if (c == 1 || c == 4) begin
        checks++;
        if (ram_addr_o !== ((c == 1) ? 24'h000014 : 24'h000010)) begin
          errors++;
          $display("FAIL tie_order c%0d: got addr=%h want %h", c, ram_addr_o,
                   (c == 1) ? 24'h000014 : 24'h000010);
        end
      end
      if (d_ack_o)  d_req_i  = 1'b0;
      if (if_ack_o) if_req_i = 1'b0;
    end
    checks++;
    if (if_data_o !== 32'h0010_0093 || d_rdata_o !== 32'h1122_BEEF) begin
      errors++;
      $display("FAIL tie_data: got if_data=%h d_rdata=%h, want 00100093 1122beef",
               if_data_o, d_rdata_o);
    end
  endtask

  task automatic test_back_to_back();
    int acks;
    do_reset();
    acks = 0;
    @(negedge clk_i);
    if_req_i = 1'b1;
    d_req_i  = 1'b1;
    for (int c = 0; c < 15; c++) begin
      if (c > 0) @(negedge clk_i);
      checks++;
      if (d_ack_o !== (c == 3 || c == 9) || if_ack_o !== (c == 6 || c == 12)) begin
        errors++;
        $display("FAIL b2b_ack c%0d: got d_ack=%b if_ack=%b, want d_ack=%b if_ack=%b",
                 c, d_ack_o, if_ack_o, (c == 3 || c == 9), (c == 6 || c == 12));
      end
      if (d_ack_o || if_ack_o) acks++;
      if (c >= 12) begin
        d_req_i  = 1'b0;
        if_req_i = 1'b0;
      end else begin
        d_req_i  = ~d_ack_o;
        if_req_i = ~if_ack_o;
      end
    end
    checks++;
    if (acks != 4) begin
      errors++;
      $display("FAIL b2b_count: got %0d acks want 4", acks);
    end
    checks++;
    if (d_rdata_o !== 32'h1122_BEEF || if_data_o !== 32'h0010_0093) begin
      errors++;
      $display("FAIL b2b_data: got d_rdata=%h if_data=%h, want 1122beef 00100093",
               d_rdata_o, if_data_o);
    end
  endtask

  task automatic test_reset_load();
    @(negedge clk_i);
    checks++;
    if (d_rdata_o !== 32'h1122_BEEF) begin
      errors++;
      $display("FAIL rst_load_pre: got d_rdata=%h want 1122beef", d_rdata_o);
    end
    d_addr_i  = 24'h000014;
    d_wmask_i = 4'b0000;
    d_req_i   = 1'b1;
    @(negedge clk_i);
    checks++;
    if (ram_rstb_o !== 1'b1 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL rst_load_access: got rstb=%b busy=%b want 1 1", ram_rstb_o, busy_o);
    end
    rst_i   = 1'b1;
    d_req_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0;
    checks++;
    if (busy_o !== 1'b0 || ram_rstb_o !== 1'b0 || d_rdata_o !== 32'h0 || d_ack_o !== 1'b0) begin
      errors++;
      $display("FAIL rst_load_after: got busy=%b rstb=%b d_rdata=%h ack=%b, want 0 0 0 0",
               busy_o, ram_rstb_o, d_rdata_o, d_ack_o);
    end
    for (int c = 3; c < 6; c++) begin
      @(negedge clk_i);
      checks++;
      if (d_ack_o !== 1'b0) begin
        errors++;
        $display("FAIL rst_load_noack c%0d: got d_ack=%b want 0", c, d_ack_o);
      end
    end
    if_addr_i = 24'h000010;
    if_req_i  = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) @(negedge clk_i);
      checks++;
      if (if_ack_o !== (c == 3)) begin
        errors++;
        $display("FAIL rst_load_fetch c%0d: got if_ack=%b want %b", c, if_ack_o, (c == 3));
      end
      if (if_ack_o) if_req_i = 1'b0;
    end
  endtask

  task automatic test_reset_store();
    @(negedge clk_i);
    d_addr_i  = 24'h000020;
    d_wdata_i = 32'hCAFE_F00D;
    d_wmask_i = 4'hF;
    d_req_i   = 1'b1;
    @(negedge clk_i);
    checks++;
    if (ram_mask_o !== 4'hF || ram_addr_o !== 24'h000020) begin
      errors++;
      $display("FAIL rst_store_access: got mask=%h addr=%h want f 000020", ram_mask_o, ram_addr_o);
    end
    rst_i   = 1'b1;
    d_req_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0;
    checks++;
    if (busy_o !== 1'b0 || ram_mask_o !== 4'h0 || d_ack_o !== 1'b0) begin
      errors++;
      $display("FAIL rst_store_after: got busy=%b mask=%h ack=%b want 0 0 0",
               busy_o, ram_mask_o, d_ack_o);
    end
    for (int c = 3; c < 6; c++) begin
      @(negedge clk_i);
      checks++;
      if (d_ack_o !== 1'b0) begin
        errors++;
        $display("FAIL rst_store_noack c%0d: got d_ack=%b want 0", c, d_ack_o);
      end
    end
    d_wmask_i = 4'h0;
    d_wdata_i = 32'h0;
    d_req_i   = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) @(negedge clk_i);
      checks++;
      if (d_ack_o !== (c == 3)) begin
        errors++;
        $display("FAIL rst_store_readback_ack c%0d: got %b want %b", c, d_ack_o, (c == 3));
      end
      if (d_ack_o) d_req_i = 1'b0;
    end
    checks++;
    if (d_rdata_o !== 32'hCAFE_F00D) begin
      errors++;
      $display("FAIL rst_store_readback: got %h want cafef00d", d_rdata_o);
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_store_load();
    test_tie();
    test_back_to_back();
    test_reset_load();
    test_reset_store();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
